register_file: RTL
==================

// Module: register_file
// PURPOSE
//  MIPS register file: 32 x 32-bit GPRs, two combinational read ports, one synchronous write port.
//  Sits directly upstream of the ALU: RD1 drives ALU A; RD2 drives ALU B (via the ALUSrc mux).
//  The write port takes the result of the ALU or the memory result selected by MemtoReg.
//  Register 0 is hardwired to zero, per the MIPS ISA.
// PARAMETERS
//  WIDTH   32  data width of each register and of RD1/RD2/WD
//  DEPTH   32  number of registers (index 0 is constant zero)
//  ADDR_W  5   address width; DEPTH == 2**ADDR_W
//  BYPASS  1   1: a write in the current cycle is forwarded to a matching read port; 0: no forwarding
// PORTS
//  CLK    in   1       clock; state changes on the rising edge
//  RST_N  in   1       asynchronous reset, active-low
//  RA1    in   ADDR_W  read address, port 1 (rs)
//  RA2    in   ADDR_W  read address, port 2 (rt)
//  RD1    out  WIDTH   read data, port 1 -> ALU A
//  RD2    out  WIDTH   read data, port 2 -> ALU B path
//  WE     in   1       write enable (RegWrite)
//  WA     in   ADDR_W  write address (rd or rt, after RegDst mux)
//  WD     in   WIDTH   write data (ALU OUT or memory data)
// BEHAVIOUR
//  - Reset: when RST_N falls, registers 1..DEPTH-1 clear to 0 immediately, without waiting for CLK.
//    While RST_N=0, all registers hold 0, writes are ignored, bypass is disabled and RD1=RD2=0.
//  - Reset release: the first rising CLK edge with RST_N=1 already honours WE.
//    If RST_N is asserted mid-cycle, any pending write is lost and the registers stay 0.
//  - Write: on rising CLK with RST_N=1, WE=1 and WA!=0, mem[WA] <= WD.
//    A write with WA=0 is discarded silently. WE=0 leaves all state unchanged.
//  - Read: RDx is combinational from RAx (zero-cycle latency).
//    RAx=0 always gives 0, regardless of WE/WA/WD or BYPASS.
//  - BYPASS=1: if WE=1, WA!=0 and WA==RAx, then RDx=WD in the same cycle (write-through).
//    Both ports may bypass at the same time when RA1==RA2==WA.
//  - BYPASS=0: RDx returns the pre-edge value until the rising edge commits the write.
//    It returns the new value after that edge.
//  - Both read ports are independent; reading the same address on both ports is legal.
//  - There is no full/empty state and no wrap. Every address is in range because DEPTH == 2**ADDR_W.
//  - X-free: with RST_N=1 and known inputs, RD1/RD2 are never X after the first reset.
// TESTING
//  1. Pulse RST_N low asynchronously between edges, then read all 32 addresses -> every RD1/RD2 = 0.
//  2. WE=1, WA=5, WD=0xDEADBEEF, one edge; RA1=5 -> RD1=0xDEADBEEF. Then WE=1, WA=0, WD=0x1234 -> RA2=0 gives RD2=0.
//  3. BYPASS=1: mem[9]=0x11; WE=1, WA=9, WD=0x22, RA1=RA2=9 before the edge -> RD1=RD2=0x22.
//     BYPASS=0, same stimulus -> 0x11 before the edge, 0x22 after it.
//  4. mem[3]=0xA5A5A5A5; assert RST_N low mid-cycle with WE=1, WA=3, WD=0x1 -> RD=0 during reset.
//     Release RST_N with WE=0 -> mem[3] = 0.
//  5. Write 0xFFFFFFFF to r1 and 0x00000001 to r2; RA1=1, RA2=2 -> RD1=0xFFFFFFFF, RD2=0x1.
//     Feed these to the ALU with SELECT=010 -> ALU OUT=0, ZERO=1 (end-to-end check).
//  6. Random test: 10k cycles of random WE/WA/WD/RA1/RA2 against a reference model array.
//     RD1/RD2 must match the model every cycle, and r0 must stay 0 throughout.

Source files
------------

// File: rtl/register_file.sv
// MIPS general-purpose register file: DEPTH x WIDTH registers, two combinational read
// ports, one synchronous write port, register 0 constant zero, optional write-through bypass.
module register_file #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [WIDTH-1:0]  wd
);

   localparam logic bypass_en_c = (BYPASS != 32'sd0);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             wr_valid_s;
   logic             byp1_s;
   logic             byp2_s;
   logic [WIDTH-1:0] rd1_s;
   logic [WIDTH-1:0] rd2_s;

   // A write to address 0 is dropped here, so mem_r[0] stays at its reset value of zero.
   assign wr_valid_s = we && (wa != {ADDR_W{1'b0}});

   // Bypass match per read port; forced off while reset is asserted.
   always_comb begin
      byp1_s = 1'b0;
      byp2_s = 1'b0;
      if (bypass_en_c && rst_n && wr_valid_s) begin
         byp1_s = (wa == ra1);
         byp2_s = (wa == ra2);
      end else begin
         byp1_s = 1'b0;
         byp2_s = 1'b0;
      end
   end

   // Register array: asynchronous clear, write on rising edge when the write is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (wr_valid_s) begin
         mem_r[wa] <= wd;
      end
   end

   // Read port 1: zero in reset or for r0, forwarded write data on a bypass hit.
   always_comb begin
      rd1_s = {WIDTH{1'b0}};
      if (!rst_n) begin
         rd1_s = {WIDTH{1'b0}};
      end else if (ra1 == {ADDR_W{1'b0}}) begin
         rd1_s = {WIDTH{1'b0}};
      end else if (byp1_s) begin
         rd1_s = wd;
      end else begin
         rd1_s = mem_r[ra1];
      end
   end

   // Read port 2: same rules as port 1, fully independent of it.
   always_comb begin
      rd2_s = {WIDTH{1'b0}};
      if (!rst_n) begin
         rd2_s = {WIDTH{1'b0}};
      end else if (ra2 == {ADDR_W{1'b0}}) begin
         rd2_s = {WIDTH{1'b0}};
      end else if (byp2_s) begin
         rd2_s = wd;
      end else begin
         rd2_s = mem_r[ra2];
      end
   end

   assign rd1 = rd1_s;
   assign rd2 = rd2_s;

endmodule
